// File: rtl/johnson_code_monitor.sv
// Receive-side decoder/checker for Johnson (or one-hot ring) counter codes with lock tracking.
// Optional macro JOHNSON_MON_HOLD_EN: a repeated legal position is accepted as a hold instead of a step error.
module johnson_code_monitor #(
  parameter int N        = 4,
  parameter int RING     = 0,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8,
  localparam int IW      = $clog2(2 * N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     code_in,
  input  logic             clr_err,
  output logic [IW-1:0]    idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             illegal,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state_dbg
);

  localparam int M = (RING != 0) ? N : 2 * N;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] prev;
  logic [3:0]    good_cnt;

  int            ones;
  logic [N:0]    run_mask;
  logic          legal;
  logic [IW-1:0] dec;
  logic [IW-1:0] succ_idx;
  logic          is_succ;
  logic          is_hold;
  logic          err_ev;

  assign state_dbg = state;

  // Legal Johnson words are a run of ones anchored at the LSB (MSB=0) or at the MSB (MSB=1).
  always_comb begin
    ones     = 0;
    run_mask = '0;
    legal    = 1'b0;
    dec      = '0;
    for (int i = 0; i < N; i++) begin
      if (code_in[i]) ones++;
    end
    if (RING != 0) begin
      legal = (ones == 1);
      for (int i = 0; i < N; i++) begin
        if (code_in[i]) dec = IW'(i);
      end
    end else if (code_in[N-1]) begin
      run_mask = ((N+1)'(1) << (N - ones)) - (N+1)'(1);
      legal    = (code_in == ~run_mask[N-1:0]);
      dec      = IW'(2 * N - ones);
    end else begin
      run_mask = ((N+1)'(1) << ones) - (N+1)'(1);
      legal    = (code_in == run_mask[N-1:0]);
      dec      = IW'(ones);
    end
  end

  always_comb begin
    succ_idx = (prev == IW'(M - 1)) ? '0 : prev + IW'(1);
    is_succ  = (dec == succ_idx);
`ifdef JOHNSON_MON_HOLD_EN
    is_hold  = (dec == prev);
`else
    is_hold  = 1'b0;
`endif
    err_ev   = en && (!legal || (state == LOCKED && !is_succ && !is_hold));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= UNLOCKED;
      prev      <= '0;
      good_cnt  <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
      locked    <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      idx_valid <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      if (clr_err) begin
        err_cnt <= '0;
      end else if (err_ev && err_cnt != ERR_MAX) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
      if (en) begin
        if (!legal) begin
          illegal  <= 1'b1;
          state    <= UNLOCKED;
          locked   <= 1'b0;
          good_cnt <= '0;
        end else begin
          idx       <= dec;
          idx_valid <= 1'b1;
          prev      <= dec;
          unique case (state)
            UNLOCKED: begin
              state    <= ACQUIRE;
              good_cnt <= '0;
            end
            ACQUIRE: begin
              if (!is_hold) begin
                if (is_succ) begin
                  if (good_cnt == 4'(LOCK_CNT - 1)) begin
                    state    <= LOCKED;
                    locked   <= 1'b1;
                    good_cnt <= '0;
                  end else begin
                    good_cnt <= good_cnt + 4'd1;
                  end
                end else begin
                  good_cnt <= '0;
                end
              end
            end
            LOCKED: begin
              if (!is_hold && !is_succ) begin
                seq_err  <= 1'b1;
                state    <= ACQUIRE;
                locked   <= 1'b0;
                good_cnt <= '0;
              end
            end
            default: begin
              state  <= UNLOCKED;
              locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
